eigen_sched: RTL and testbench

// - Shares one 2x2 eigen core among NCH requesters. Each requester is one covariance

---
 rtl/eigen_sched.sv | 199 +++++++++++++++++++
 tb/tb_eigen_sched.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/eigen_sched.sv
// eigen_sched: round-robin scheduler sharing one 2x2 eigen core among NCH covariance
// streams, with a latency-matched tag pipe, flush/drain FSM and sticky sync-error flag.
// Optional issue throttle: define EIGEN_SCHED_THROTTLE_EN to add the issue_gap input.
module eigen_sched #(
   parameter int NCH      = 4,
   parameter int TAG_W    = 2,
   parameter int CORE_LAT = 20,
   parameter int DW       = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [NCH-1:0]        req_valid,
   output logic [NCH-1:0]        req_ready,
   input  logic [NCH*3*DW-1:0]   req_data,
   input  logic                  flush,
   output logic                  flush_done,
   output logic                  busy,
`ifdef EIGEN_SCHED_THROTTLE_EN
   input  logic [3:0]            issue_gap,
`endif
   output logic                  core_din_valid,
   output logic [DW-1:0]         core_r11,
   output logic [DW-1:0]         core_r22,
   output logic [DW-1:0]         core_r12,
   input  logic [DW-1:0]         core_lamb1,
   input  logic [DW-1:0]         core_lamb2,
   input  logic [DW-1:0]         core_eig1_y,
   input  logic [DW-1:0]         core_eig2_y,
   input  logic [DW-1:0]         core_eig_x,
   input  logic                  core_dout_valid,
   output logic [DW-1:0]         res_lamb1,
   output logic [DW-1:0]         res_lamb2,
   output logic [DW-1:0]         res_eig1_y,
   output logic [DW-1:0]         res_eig2_y,
   output logic [DW-1:0]         res_eig_x,
   output logic [TAG_W-1:0]      res_tag,
   output logic                  res_valid,
   output logic                  err_sync
);
   localparam int PTR_W = (NCH > 1) ? $clog2(NCH) : 1;

   // Handshake: a requester transfers when req_valid[k] & req_ready[k]; req_ready is
   // combinational from req_valid, ptr and FSM state, and is one-hot or zero.
   typedef enum logic [1:0] {S_RUN, S_DRAIN, S_DONE, S_HOLD} state_e;
   state_e state_q, state_d;

   logic                   grant_en;
   logic                   gap_open;
   logic                   gnt_any;
   logic [PTR_W-1:0]       gnt_idx;
   logic [PTR_W-1:0]       ptr_q, ptr_d;
   logic                   din_valid_q, din_valid_d;
   logic [3*DW-1:0]        issue_q, issue_d;
   logic [TAG_W-1:0]       tag_q, tag_d;
   logic [CORE_LAT-1:0]    pv_q, pv_d;
   logic [TAG_W-1:0]       pt_q [CORE_LAT];
   logic [TAG_W-1:0]       pt_d [CORE_LAT];
   logic [5*DW-1:0]        res_q, res_d;
   logic [TAG_W-1:0]       res_tag_q, res_tag_d;
   logic                   res_valid_q, res_valid_d;
   logic                   err_q, err_d;
   logic                   pipe_v_out;
   logic                   drain_idle;

   function automatic logic [PTR_W-1:0] wrap_idx(input logic [PTR_W-1:0] p, input int off);
      int s;
      s = int'(p) + off;
      if (s >= NCH) s = s - NCH;
      return PTR_W'(s);
   endfunction

`ifdef EIGEN_SCHED_THROTTLE_EN
   logic [3:0] gap_q, gap_d;

   always_comb begin
      gap_d = gap_q;
      if (gnt_any)            gap_d = issue_gap;
      else if (gap_q != 4'd0) gap_d = gap_q - 4'd1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) gap_q <= 4'd0;
      else        gap_q <= gap_d;
   end

   assign gap_open = (gap_q == 4'd0);
`else
   assign gap_open = 1'b1;
`endif

   // Search order starts at ptr and wraps; the first valid requester wins.
   always_comb begin
      gnt_any   = 1'b0;
      gnt_idx   = '0;
      req_ready = '0;
      if (grant_en) begin
         for (int i = 0; i < NCH; i++) begin
            if (!gnt_any && req_valid[wrap_idx(ptr_q, i)]) begin
               gnt_any = 1'b1;
               gnt_idx = wrap_idx(ptr_q, i);
            end
         end
      end
      if (gnt_any) req_ready[gnt_idx] = 1'b1;
   end

   always_comb begin
      ptr_d       = gnt_any ? wrap_idx(gnt_idx, 1) : ptr_q;
      din_valid_d = gnt_any;
      issue_d     = gnt_any ? req_data[int'(gnt_idx)*3*DW +: 3*DW] : issue_q;
      tag_d       = gnt_any ? TAG_W'(gnt_idx) : tag_q;
      pv_d        = {pv_q[CORE_LAT-2:0], din_valid_q};
      pt_d[0]     = tag_q;
      for (int i = 1; i < CORE_LAT; i++) pt_d[i] = pt_q[i-1];
   end

   // A spurious core result is still reported, but carries tag 0.
   assign pipe_v_out = pv_q[CORE_LAT-1];

   always_comb begin
      res_valid_d = core_dout_valid;
      res_d       = res_q;
      res_tag_d   = res_tag_q;
      if (core_dout_valid) begin
         res_d     = {core_lamb1, core_lamb2, core_eig1_y, core_eig2_y, core_eig_x};
         res_tag_d = pipe_v_out ? pt_q[CORE_LAT-1] : '0;
      end
      err_d = err_q | (core_dout_valid != pipe_v_out);
   end

   assign drain_idle = ~|pv_q & ~din_valid_q & ~core_dout_valid;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_RUN;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         S_RUN:   if (flush)      state_d = S_DRAIN;
         S_DRAIN: if (drain_idle) state_d = S_DONE;
         S_DONE:  state_d = flush ? S_HOLD : S_RUN;
         S_HOLD:  if (!flush)     state_d = S_RUN;
         default: state_d = S_RUN;
      endcase
   end

   always_comb begin
      grant_en   = 1'b0;
      flush_done = 1'b0;
      case (state_q)
         S_RUN:   grant_en   = !flush && gap_open;
         S_DONE:  flush_done = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q       <= '0;
         din_valid_q <= 1'b0;
         issue_q     <= '0;
         tag_q       <= '0;
         pv_q        <= '0;
         for (int i = 0; i < CORE_LAT; i++) pt_q[i] <= '0;
         res_q       <= '0;
         res_tag_q   <= '0;
         res_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         ptr_q       <= ptr_d;
         din_valid_q <= din_valid_d;
         issue_q     <= issue_d;
         tag_q       <= tag_d;
         pv_q        <= pv_d;
         for (int i = 0; i < CORE_LAT; i++) pt_q[i] <= pt_d[i];
         res_q       <= res_d;
         res_tag_q   <= res_tag_d;
         res_valid_q <= res_valid_d;
         err_q       <= err_d;
      end
   end

   assign busy           = (|pv_q) | din_valid_q | (state_q != S_RUN);
   assign core_din_valid = din_valid_q;
   assign core_r11       = issue_q[3*DW-1 -: DW];
   assign core_r22       = issue_q[2*DW-1 -: DW];
   assign core_r12       = issue_q[DW-1:0];
   assign res_lamb1      = res_q[5*DW-1 -: DW];
   assign res_lamb2      = res_q[4*DW-1 -: DW];
   assign res_eig1_y     = res_q[3*DW-1 -: DW];
   assign res_eig2_y     = res_q[2*DW-1 -: DW];
   assign res_eig_x      = res_q[DW-1:0];
   assign res_tag        = res_tag_q;
   assign res_valid      = res_valid_q;
   assign err_sync       = err_q;

endmodule

// File: tb/tb_eigen_sched.sv
// Bench for eigen_sched: random request streams, a behavioural core stand-in and a
// result scoreboard; the throttle scenario is built when EIGEN_SCHED_THROTTLE_EN is defined.
module tb_eigen_sched;
   localparam int NCH      = 4;
   localparam int TAG_W    = 2;
   localparam int CORE_LAT = 20;
   localparam int DW       = 16;
   localparam int LAT      = CORE_LAT + 2;
   localparam int EW       = 32 + TAG_W + 5*DW;

   logic                 clk = 1'b0;
   logic                 rst_n = 1'b0;
   logic [NCH-1:0]       req_valid = '0;
   logic [NCH-1:0]       req_ready;
   logic [NCH*3*DW-1:0]  req_data = '0;
   logic                 flush = 1'b0;
   logic                 flush_done, busy;
`ifdef EIGEN_SCHED_THROTTLE_EN
   logic [3:0]           issue_gap = 4'd0;
`endif
   logic                 core_din_valid;
   logic [DW-1:0]        core_r11, core_r22, core_r12;
   logic [DW-1:0]        core_lamb1, core_lamb2, core_eig1_y, core_eig2_y, core_eig_x;
   logic                 core_dout_valid;
   logic [DW-1:0]        res_lamb1, res_lamb2, res_eig1_y, res_eig2_y, res_eig_x;
   logic [TAG_W-1:0]     res_tag;
   logic                 res_valid, err_sync;

   int errors = 0;
   int checks = 0;
   int cyc = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   eigen_sched #(.NCH(NCH), .TAG_W(TAG_W), .CORE_LAT(CORE_LAT), .DW(DW)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_data(req_data), .flush(flush), .flush_done(flush_done), .busy(busy),
`ifdef EIGEN_SCHED_THROTTLE_EN
      .issue_gap(issue_gap),
`endif
      .core_din_valid(core_din_valid), .core_r11(core_r11), .core_r22(core_r22),
      .core_r12(core_r12), .core_lamb1(core_lamb1), .core_lamb2(core_lamb2),
      .core_eig1_y(core_eig1_y), .core_eig2_y(core_eig2_y), .core_eig_x(core_eig_x),
      .core_dout_valid(core_dout_valid), .res_lamb1(res_lamb1), .res_lamb2(res_lamb2),
      .res_eig1_y(res_eig1_y), .res_eig2_y(res_eig2_y), .res_eig_x(res_eig_x),
      .res_tag(res_tag), .res_valid(res_valid), .err_sync(err_sync)
   );

   // Core stand-in: a fixed arithmetic function of the inputs, CORE_LAT cycles later.
   function automatic logic [5*DW-1:0] core_fn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                               input logic [DW-1:0] c);
      logic [DW-1:0] s;
      s = a + c;
      return {a, b, c, a ^ b, s};
   endfunction

   logic [CORE_LAT-1:0] cm_v;
   logic [5*DW-1:0]     cm_d [CORE_LAT];
   logic                inject = 1'b0;
   logic [5*DW-1:0]     inj_data = '0;

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) cm_v <= '0;
      else begin
         cm_v    <= {cm_v[CORE_LAT-2:0], core_din_valid};
         cm_d[0] <= core_fn(core_r11, core_r22, core_r12);
         for (int i = 1; i < CORE_LAT; i++) cm_d[i] <= cm_d[i-1];
      end
   end

   assign core_dout_valid = cm_v[CORE_LAT-1] | inject;
   assign {core_lamb1, core_lamb2, core_eig1_y, core_eig2_y, core_eig_x} =
      inject ? inj_data : cm_d[CORE_LAT-1];

   // Scoreboard: entries are {due cycle, tag, expected result}, in transfer order.
   logic [EW-1:0] exp_q[$];
   logic [EW-1:0] sb_e;
   logic          spurious_ok = 1'b0;

   always @(negedge clk) begin
      if (rst_n) begin
         if (res_valid) begin
            if (spurious_ok) spurious_ok = 1'b0;
            else if (exp_q.size() == 0) begin
               checks++; errors++;
               $display("FAIL sb_unexpected_result tag=%0d cyc=%0d expected no result", res_tag, cyc);
            end else begin
               sb_e = exp_q.pop_front();
               checks++;
               if ({res_tag, res_lamb1, res_lamb2, res_eig1_y, res_eig2_y, res_eig_x} !== sb_e[TAG_W+5*DW-1:0]
                   || sb_e[EW-1 -: 32] !== 32'(cyc)) begin
                  errors++;
                  $display("FAIL sb_result got tag=%0d data=%h at cyc %0d, expected tag=%0d data=%h at cyc %0d",
                           res_tag, {res_lamb1, res_lamb2, res_eig1_y, res_eig2_y, res_eig_x}, cyc,
                           sb_e[5*DW +: TAG_W], sb_e[5*DW-1:0], sb_e[EW-1 -: 32]);
               end
            end
         end else if (exp_q.size() != 0) begin
            sb_e = exp_q[0];
            if (int'(sb_e[EW-1 -: 32]) <= cyc) begin
               void'(exp_q.pop_front());
               checks++; errors++;
               $display("FAIL sb_missing_result tag=%0d due=%0d cyc=%0d res_valid=0 expected 1",
                        sb_e[5*DW +: TAG_W], sb_e[EW-1 -: 32], cyc);
            end
         end
      end
   end

   // Requester model: pending flag and held data per requester, plus the arbitration rule.
   logic [NCH-1:0]  pend_v = '0;
   logic [3*DW-1:0] pend_d [NCH];
   int              model_ptr = 0;
   int              model_gap = 0;
   int              gap_val = 0;

   function automatic int model_pick(input logic [NCH-1:0] v, input logic blocked);
      if (blocked || model_gap > 0) return -1;
      for (int i = 0; i < NCH; i++)
         if (v[(model_ptr + i) % NCH]) return (model_ptr + i) % NCH;
      return -1;
   endfunction

   task automatic refill(input logic [NCH-1:0] mask);
      logic [63:0] r;
      for (int k = 0; k < NCH; k++) begin
         if (mask[k] && !pend_v[k]) begin
            r = {$urandom, $urandom};
            pend_v[k] = 1'b1;
            pend_d[k] = r[3*DW-1:0];
         end
      end
   endtask

   task automatic drive_cycle(input logic fl, input logic blocked,
                              output logic [NCH-1:0] got, output logic [NCH-1:0] exp_v);
      int k;
      logic [31:0] due;
      @(negedge clk);
      flush = fl;
      req_valid = pend_v;
      for (int j = 0; j < NCH; j++) req_data[j*3*DW +: 3*DW] = pend_d[j];
      #1;
      got = req_ready;
      k = model_pick(pend_v, blocked);
      exp_v = '0;
      if (k >= 0) begin
         exp_v[k] = 1'b1;
         due = 32'(cyc + LAT);
         exp_q.push_back({due, TAG_W'(k),
                          core_fn(pend_d[k][3*DW-1 -: DW], pend_d[k][2*DW-1 -: DW], pend_d[k][DW-1:0])});
         pend_v[k] = 1'b0;
         model_ptr = (k + 1) % NCH;
         model_gap = gap_val;
      end else if (model_gap > 0) model_gap--;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      req_valid = '0;
      flush = 1'b0;
      inject = 1'b0;
      pend_v = '0;
      exp_q.delete();
      model_ptr = 0;
      model_gap = 0;
   endtask

   task automatic release_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic drain(input string name);
      logic [NCH-1:0] got, exp_v;
      int n = 0;
      while ((exp_q.size() != 0 || pend_v != '0) && n < 300) begin
         drive_cycle(1'b0, 1'b0, got, exp_v);
         checks++;
         if (got !== exp_v) begin
            errors++;
            $display("FAIL %s_ready got=%b expected=%b cyc=%0d", name, got, exp_v, cyc);
         end
         n++;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s_timeout pending=%0d expected 0", name, exp_q.size());
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      do_reset();
      #1;
      checks++; if (req_ready !== '0) begin errors++; $display("FAIL reset_req_ready got=%b expected 0", req_ready); end
      checks++; if (flush_done !== 1'b0) begin errors++; $display("FAIL reset_flush_done got=%b expected 0", flush_done); end
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b expected 0", busy); end
      checks++; if (core_din_valid !== 1'b0) begin errors++; $display("FAIL reset_din_valid got=%b expected 0", core_din_valid); end
      checks++;
      if ({core_r11, core_r22, core_r12} !== '0) begin
         errors++; $display("FAIL reset_core_r got=%h expected 0", {core_r11, core_r22, core_r12});
      end
      checks++;
      if ({res_valid, res_tag, res_lamb1, res_lamb2, res_eig1_y, res_eig2_y, res_eig_x} !== '0) begin
         errors++; $display("FAIL reset_res got=%h expected 0",
                            {res_valid, res_tag, res_lamb1, res_lamb2, res_eig1_y, res_eig2_y, res_eig_x});
      end
      checks++; if (err_sync !== 1'b0) begin errors++; $display("FAIL reset_err_sync got=%b expected 0", err_sync); end
      release_reset();
   endtask

   task automatic test_single_channel();
      logic [NCH-1:0] got, exp_v;
      for (int i = 0; i < 5; i++) begin
         refill(4'b0100);
         drive_cycle(1'b0, 1'b0, got, exp_v);
         checks++;
         if (got !== exp_v) begin errors++; $display("FAIL single_ready got=%b expected=%b", got, exp_v); end
      end
      drain("single");
   endtask

   task automatic test_back_to_back();
      logic [NCH-1:0] got, exp_v;
      for (int i = 0; i < 12; i++) begin
         refill('1);
         drive_cycle(1'b0, 1'b0, got, exp_v);
         checks++;
         if (got !== exp_v) begin errors++; $display("FAIL b2b_ready got=%b expected=%b", got, exp_v); end
         if (i > 0) begin
            checks++;
            if (core_din_valid !== 1'b1) begin errors++; $display("FAIL b2b_din_valid got=%b expected 1", core_din_valid); end
         end
      end
      pend_v = '0;
      drain("b2b");
   endtask

   task automatic test_pair_from_ptr2();
      logic [NCH-1:0] got, exp_v;
      refill(4'b0010);
      drive_cycle(1'b0, 1'b0, got, exp_v);
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL pair_setup_ready got=%b expected=%b", got, exp_v); end
      for (int i = 0; i < 4; i++) begin
         refill(4'b1010);
         drive_cycle(1'b0, 1'b0, got, exp_v);
         checks++;
         if (got !== exp_v) begin errors++; $display("FAIL pair_ready got=%b expected=%b", got, exp_v); end
      end
      pend_v = '0;
      drain("pair");
   endtask

   task automatic test_random();
      logic [NCH-1:0] got, exp_v;
      for (int i = 0; i < 80; i++) begin
         refill(NCH'($urandom_range(0, (1 << NCH) - 1)));
         drive_cycle(1'b0, 1'b0, got, exp_v);
         checks++;
         if (got !== exp_v) begin errors++; $display("FAIL random_ready got=%b expected=%b cyc=%0d", got, exp_v, cyc); end
      end
      drain("random");
   endtask

   task automatic test_flush();
      logic [NCH-1:0] got, exp_v;
      int nres = 0, ndone = 0, last_res = -1, done_cyc = -1, n = 0;
      for (int i = 0; i < 10; i++) begin
         refill('1);
         drive_cycle(1'b0, 1'b0, got, exp_v);
      end
      while (n < 80 && !(ndone > 0 && cyc >= done_cyc + 3)) begin
         refill('1);
         drive_cycle(1'b1, 1'b1, got, exp_v);
         checks++;
         if (got !== '0) begin errors++; $display("FAIL flush_ready got=%b expected 0 cyc=%0d", got, cyc); end
         if (n == 1) begin
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL flush_busy got=%b expected 1", busy); end
         end
         if (res_valid === 1'b1) begin nres++; last_res = cyc; end
         if (flush_done === 1'b1) begin ndone++; done_cyc = cyc; end
         n++;
      end
      checks++; if (nres != 10) begin errors++; $display("FAIL flush_results got=%0d expected 10", nres); end
      checks++; if (ndone != 1) begin errors++; $display("FAIL flush_done_count got=%0d expected 1", ndone); end
      checks++;
      if (done_cyc != last_res + 1) begin
         errors++; $display("FAIL flush_done_cycle got=%0d expected %0d", done_cyc, last_res + 1);
      end
      drive_cycle(1'b0, 1'b1, got, exp_v);
      checks++;
      if (got !== '0) begin errors++; $display("FAIL hold_ready got=%b expected 0", got); end
      drive_cycle(1'b0, 1'b0, got, exp_v);
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL resume_ready got=%b expected=%b", got, exp_v); end
      drain("flush");
   endtask

   task automatic test_sync_error();
      logic [63:0] r;
      @(negedge clk);
      r = {$urandom, $urandom};
      inj_data = {r[DW-1:0], r[2*DW-1 -: DW], r[3*DW-1 -: DW], r[4*DW-1 -: DW], r[DW-1:0] ^ 16'h5a5a};
      inject = 1'b1;
      spurious_ok = 1'b1;
      @(negedge clk);
      inject = 1'b0;
      #1;
      checks++; if (err_sync !== 1'b1) begin errors++; $display("FAIL sync_err got=%b expected 1", err_sync); end
      checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL sync_res_valid got=%b expected 1", res_valid); end
      checks++; if (res_tag !== '0) begin errors++; $display("FAIL sync_res_tag got=%0d expected 0", res_tag); end
      checks++;
      if (res_lamb1 !== inj_data[5*DW-1 -: DW]) begin
         errors++; $display("FAIL sync_res_data got=%h expected=%h", res_lamb1, inj_data[5*DW-1 -: DW]);
      end
      repeat (5) @(negedge clk);
      checks++; if (err_sync !== 1'b1) begin errors++; $display("FAIL sync_sticky got=%b expected 1", err_sync); end
      do_reset();
      #1;
      checks++; if (err_sync !== 1'b0) begin errors++; $display("FAIL sync_reset_err got=%b expected 0", err_sync); end
      checks++;
      if ({res_valid, res_tag, res_lamb1, busy, flush_done, core_din_valid, req_ready} !== '0) begin
         errors++; $display("FAIL sync_reset_outputs got=%h expected 0",
                            {res_valid, res_tag, res_lamb1, busy, flush_done, core_din_valid, req_ready});
      end
      release_reset();
   endtask

`ifdef EIGEN_SCHED_THROTTLE_EN
   task automatic test_throttle();
      logic [NCH-1:0] got, exp_v;
      int ngrant = 0;
      gap_val = 3;
      issue_gap = 4'd3;
      for (int i = 0; i < 16; i++) begin
         refill('1);
         drive_cycle(1'b0, 1'b0, got, exp_v);
         checks++;
         if (got !== exp_v) begin errors++; $display("FAIL throttle_ready got=%b expected=%b", got, exp_v); end
         if (got != '0) ngrant++;
      end
      checks++; if (ngrant != 4) begin errors++; $display("FAIL throttle_count got=%0d expected 4", ngrant); end
      pend_v = '0;
      drain("throttle");
      gap_val = 0;
      issue_gap = 4'd0;
   endtask
`endif

   initial begin
      test_reset();
      test_single_channel();
      test_back_to_back();
      test_pair_from_ptr2();
      test_random();
      test_flush();
      test_sync_error();
`ifdef EIGEN_SCHED_THROTTLE_EN
      test_throttle();
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
